punc_mem_arbiter: RTL and testbench

- Shares the single-port PUnC LC3 memory among three requesters: CPU instruction fetch, CPU data access (LD/LDI/LDR/ST/STI/STR), and a debug/loader port.
- Sits between the PUnC control/datapath pair and the memory.
- Serialises accesses, sequences read latency and returns read data to the winning requester.
- Fixed priority, with a starvation guard for fetch.

---
 rtl/punc_mem_pkg.sv | 18 +
 rtl/punc_mem_prio_pick.sv | 31 +++
 rtl/punc_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_punc_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/punc_mem_pkg.sv
// Shared definitions for the PUnC memory arbiter: FSM state encoding,
// requester ids and the default memory read latency.
package punc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] REQ_FETCH = 2'd0;
  localparam logic [1:0] REQ_DATA  = 2'd1;
  localparam logic [1:0] REQ_DBG   = 2'd2;

  localparam int DEFAULT_RD_LAT = 1;

endpackage

// File: rtl/punc_mem_prio_pick.sv
// Combinational winner selection: debug > data > fetch, except that fetch is
// forced through once it has lost STARVE_LIM consecutive arbitrations.
module punc_mem_prio_pick
  import punc_mem_pkg::*;
#(
  parameter int STARVE_LIM = 3,
  parameter int CNT_W      = 2
) (
  input  logic             f_req,
  input  logic             d_req,
  input  logic             g_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic [1:0]       winner,
  output logic             any_req
);

  always_comb begin
    winner  = REQ_FETCH;
    any_req = f_req | d_req | g_req;
    if (f_req && (starve_cnt == CNT_W'(STARVE_LIM))) begin
      winner = REQ_FETCH;
    end else if (g_req) begin
      winner = REQ_DBG;
    end else if (d_req) begin
      winner = REQ_DATA;
    end else begin
      winner = REQ_FETCH;
    end
  end

endmodule

// File: rtl/punc_mem_arbiter.sv
// Serialises fetch, data and debug accesses onto the single-port PUnC memory,
// sequences the read latency and routes read data back to the winner.
module punc_mem_arbiter
  import punc_mem_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = DEFAULT_RD_LAT,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic              d_req,
  input  logic              g_req,
  input  logic              f_we,
  input  logic              d_we,
  input  logic              g_we,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] g_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [DATA_W-1:0] g_wdata,
  output logic              f_gnt,
  output logic              d_gnt,
  output logic              g_gnt,
  output logic              f_rvalid,
  output logic              d_rvalid,
  output logic              g_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam int LAT_W = 3;

  state_t            state, next_state;
  logic [1:0]        win_id;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [LAT_W-1:0]  lat_cnt;
  logic [CNT_W-1:0]  starve_cnt;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        pick;
  logic              any_req;
  logic              unused_f_we;

  // Fetch can never write, so its write strobe is deliberately ignored.
  assign unused_f_we = f_we;

  punc_mem_prio_pick #(
    .STARVE_LIM (STARVE_LIM),
    .CNT_W      (CNT_W)
  ) u_pick (
    .f_req      (f_req),
    .d_req      (d_req),
    .g_req      (g_req),
    .starve_cnt (starve_cnt),
    .winner     (pick),
    .any_req    (any_req)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      win_id     <= REQ_FETCH;
      win_we     <= 1'b0;
      win_addr   <= '0;
      win_wdata  <= '0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      rdata_q    <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && any_req) begin
        win_id <= pick;
        unique case (pick)
          REQ_DBG: begin
            win_we    <= g_we;
            win_addr  <= g_addr;
            win_wdata <= g_wdata;
          end
          REQ_DATA: begin
            win_we    <= d_we;
            win_addr  <= d_addr;
            win_wdata <= d_wdata;
          end
          default: begin
            win_we    <= 1'b0;
            win_addr  <= f_addr;
            win_wdata <= '0;
          end
        endcase
        if (pick == REQ_FETCH) begin
          starve_cnt <= '0;
        end else if (f_req && (starve_cnt < CNT_W'(STARVE_LIM))) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end
      if (state == ISSUE) begin
        lat_cnt <= LAT_W'(RD_LAT - 1);
      end else if (state == RWAIT && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (state == RWAIT && lat_cnt == '0) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    next_state = state;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    f_gnt      = 1'b0;
    d_gnt      = 1'b0;
    g_gnt      = 1'b0;
    f_rvalid   = 1'b0;
    d_rvalid   = 1'b0;
    g_rvalid   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) next_state = ISSUE;
      end
      ISSUE: begin
        mem_en     = 1'b1;
        mem_we     = win_we;
        mem_addr   = win_addr;
        mem_wdata  = win_wdata;
        f_gnt      = (win_id == REQ_FETCH);
        d_gnt      = (win_id == REQ_DATA);
        g_gnt      = (win_id == REQ_DBG);
        next_state = win_we ? IDLE : RWAIT;
      end
      RWAIT: begin
        if (lat_cnt == '0) next_state = RESP;
      end
      RESP: begin
        f_rvalid   = (win_id == REQ_FETCH);
        d_rvalid   = (win_id == REQ_DATA);
        g_rvalid   = (win_id == REQ_DBG);
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign rdata = rdata_q;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Scoreboard bench for punc_mem_arbiter: an RD_LAT=1 instance for the bulk of
// the directed vectors and an RD_LAT=4 instance for the long-latency read.
module tb_punc_mem_arbiter;
  import punc_mem_pkg::*;

  typedef struct {
    int          cyc;
    logic        is_rv;
    logic [1:0]  id;
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  ev_t  q1[$];
  ev_t  q4[$];

  logic        f_req, d_req, g_req, f_we, d_we, g_we;
  logic [15:0] f_addr, d_addr, g_addr, d_wdata, g_wdata;
  logic        f_gnt, d_gnt, g_gnt, f_rvalid, d_rvalid, g_rvalid;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_we, busy;

  logic        f4_req, d4_req, g4_req, f4_we, d4_we, g4_we;
  logic [15:0] f4_addr, d4_addr, g4_addr, d4_wdata, g4_wdata;
  logic        f4_gnt, d4_gnt, g4_gnt, f4_rvalid, d4_rvalid, g4_rvalid;
  logic [15:0] rdata4, mem_addr4, mem_wdata4, mem_rdata4;
  logic        mem_en4, mem_we4, busy4;

  logic [15:0] mem1 [65536];
  logic        wr1  [65536];
  logic [15:0] pipe1;
  logic [15:0] pipe4 [4];
  logic        f_req_q, d_req_q, g_req_q;
  logic [5:0]  mv1, mv4;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  punc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1), .STARVE_LIM(3)) u_dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .d_req(d_req), .g_req(g_req),
    .f_we(f_we), .d_we(d_we), .g_we(g_we),
    .f_addr(f_addr), .d_addr(d_addr), .g_addr(g_addr),
    .d_wdata(d_wdata), .g_wdata(g_wdata),
    .f_gnt(f_gnt), .d_gnt(d_gnt), .g_gnt(g_gnt),
    .f_rvalid(f_rvalid), .d_rvalid(d_rvalid), .g_rvalid(g_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  punc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(4), .STARVE_LIM(3)) u_dut4 (
    .clk(clk), .rst(rst),
    .f_req(f4_req), .d_req(d4_req), .g_req(g4_req),
    .f_we(f4_we), .d_we(d4_we), .g_we(g4_we),
    .f_addr(f4_addr), .d_addr(d4_addr), .g_addr(g4_addr),
    .d_wdata(d4_wdata), .g_wdata(g4_wdata),
    .f_gnt(f4_gnt), .d_gnt(d4_gnt), .g_gnt(g4_gnt),
    .f_rvalid(f4_rvalid), .d_rvalid(d4_rvalid), .g_rvalid(g4_rvalid),
    .rdata(rdata4), .mem_en(mem_en4), .mem_we(mem_we4),
    .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4),
    .busy(busy4)
  );

  // Unwritten locations read back as a fixed pattern; 0x3000 holds 0x1234.
  function automatic logic [15:0] preload(input logic [15:0] a);
    return (a == 16'h3000) ? 16'h1234 : (a ^ 16'hA5A5);
  endfunction

  // Memory models: data appears exactly RD_LAT cycles after mem_en, junk otherwise.
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem1[mem_addr] <= mem_wdata;
      wr1[mem_addr]  <= 1'b1;
    end
    if (mem_en && !mem_we) pipe1 <= (wr1[mem_addr] === 1'b1) ? mem1[mem_addr] : preload(mem_addr);
    else pipe1 <= 16'hDEAD;
    pipe4[0] <= (mem_en4 && !mem_we4) ? preload(mem_addr4) : 16'hDEAD;
    for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
  end
  assign mem_rdata  = pipe1;
  assign mem_rdata4 = pipe4[3];

  // A requester must hold req until its grant.
  always @(posedge clk) begin
    if (rst && ((f_req_q && !f_req && !f_gnt) || (d_req_q && !d_req && !d_gnt) ||
                (g_req_q && !g_req && !g_gnt)))
      $error("[TB] request dropped before its grant");
    f_req_q <= f_req;
    d_req_q <= d_req;
    g_req_q <= g_req;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] expVec(input logic is_rv, input logic [1:0] id);
    logic [2:0] b;
    b = {id == REQ_FETCH, id == REQ_DATA, id == REQ_DBG};
    return is_rv ? {3'b000, b} : {b, 3'b000};
  endfunction

  task automatic expectEv(input bit which, input int c, input logic is_rv, input logic [1:0] id,
                          input logic we, input logic [15:0] addr, input logic [15:0] data);
    ev_t e;
    e.cyc = c; e.is_rv = is_rv; e.id = id; e.we = we; e.addr = addr; e.data = data;
    if (which) q4.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic scorePulse(input bit which, input logic [5:0] v, input logic men, input logic mwe,
                            input logic [15:0] ma, input logic [15:0] mwd, input logic [15:0] rd);
    ev_t   e;
    string tag;
    tag = which ? "dut4" : "dut1";
    checkOutput({tag, "_onehot"}, 64'($countones(v)), 64'd1);
    checkOutput({tag, "_memen_vs_gnt"}, 64'(men), 64'(|v[5:3]));
    if (v != 6'd0) begin
      if ((which ? q4.size() : q1.size()) == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL %s_unexpected: got pulses %b expected none at cycle %0d", tag, v, cyc);
      end else begin
        e = which ? q4.pop_front() : q1.pop_front();
        checkOutput({tag, "_cycle"}, 64'(cyc), 64'(e.cyc));
        checkOutput({tag, "_pulse"}, 64'(v), 64'(expVec(e.is_rv, e.id)));
        if (e.is_rv) begin
          checkOutput({tag, "_rdata"}, 64'(rd), 64'(e.data));
        end else begin
          checkOutput({tag, "_mem_we"}, 64'(mwe), 64'(e.we));
          checkOutput({tag, "_mem_addr"}, 64'(ma), 64'(e.addr));
          if (e.we) checkOutput({tag, "_mem_wdata"}, 64'(mwd), 64'(e.data));
        end
      end
    end
  endtask

  // Monitor: every gnt/rvalid pulse is matched against the next expected event.
  always @(negedge clk) begin
    mv1 = {f_gnt, d_gnt, g_gnt, f_rvalid, d_rvalid, g_rvalid};
    mv4 = {f4_gnt, d4_gnt, g4_gnt, f4_rvalid, d4_rvalid, g4_rvalid};
    if (mv1 != 6'd0 || mem_en) scorePulse(1'b0, mv1, mem_en, mem_we, mem_addr, mem_wdata, rdata);
    if (mv4 != 6'd0 || mem_en4) scorePulse(1'b1, mv4, mem_en4, mem_we4, mem_addr4, mem_wdata4, rdata4);
  end

  task automatic applyStimulus(input logic [1:0] id, input logic we, input logic [15:0] addr,
                               input logic [15:0] wdata);
    case (id)
      REQ_FETCH: begin f_req = 1'b1; f_we = we; f_addr = addr; end
      REQ_DATA:  begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
      default:   begin g_req = 1'b1; g_we = we; g_addr = addr; g_wdata = wdata; end
    endcase
  endtask

  task automatic dropReq(input logic [1:0] id);
    case (id)
      REQ_FETCH: f_req = 1'b0;
      REQ_DATA:  d_req = 1'b0;
      default:   g_req = 1'b0;
    endcase
  endtask

  task automatic waitGnt(input logic [1:0] id);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      seen = (id == REQ_FETCH) ? f_gnt : (id == REQ_DATA) ? d_gnt : g_gnt;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_gnt: got no grant for id %0d expected one within 200 cycles", id);
    end
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 100 && !idle; k++) begin
      @(negedge clk);
      idle = !busy;
    end
    if (!idle) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_idle: got busy=1 expected 0 within 100 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected one before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b0;
    {f_req, d_req, g_req, f_we, d_we, g_we} = '0;
    {f_addr, d_addr, g_addr, d_wdata, g_wdata} = '0;
    {f4_req, d4_req, g4_req, f4_we, d4_we, g4_we} = '0;
    {f4_addr, d4_addr, g4_addr, d4_wdata, g4_wdata} = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_state", {f_gnt, d_gnt, g_gnt, f_rvalid, d_rvalid, g_rvalid, mem_en, mem_we,
                busy, rdata, mem_addr, mem_wdata}, 64'd0);

    // Debug read interrupted by reset while waiting on memory.
    n = cyc;
    applyStimulus(REQ_DBG, 1'b0, 16'h3000, 16'h0000);
    expectEv(1'b0, n + 1, 1'b0, REQ_DBG, 1'b0, 16'h3000, 16'h0000);
    waitGnt(REQ_DBG);
    dropReq(REQ_DBG);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_midread", {f_gnt, d_gnt, g_gnt, f_rvalid, d_rvalid, g_rvalid, mem_en, mem_we,
                busy, rdata, mem_addr, mem_wdata}, 64'd0);
    rst = 1'b1;
    repeat (6) @(negedge clk);

    // Fetch read with f_we set: must still be issued as a read.
    n = cyc;
    applyStimulus(REQ_FETCH, 1'b1, 16'h3000, 16'h0000);
    expectEv(1'b0, n + 1, 1'b0, REQ_FETCH, 1'b0, 16'h3000, 16'h0000);
    expectEv(1'b0, n + 3, 1'b1, REQ_FETCH, 1'b0, 16'h0000, 16'h1234);
    waitGnt(REQ_FETCH);
    dropReq(REQ_FETCH);
    f_we = 1'b0;
    waitIdle();

    // Data write, then read it back.
    n = cyc;
    applyStimulus(REQ_DATA, 1'b1, 16'h4000, 16'hBEEF);
    expectEv(1'b0, n + 1, 1'b0, REQ_DATA, 1'b1, 16'h4000, 16'hBEEF);
    waitGnt(REQ_DATA);
    dropReq(REQ_DATA);
    @(negedge clk);
    checkOutput("write_back_idle", 64'(busy), 64'd0);
    n = cyc;
    applyStimulus(REQ_DATA, 1'b0, 16'h4000, 16'h0000);
    expectEv(1'b0, n + 1, 1'b0, REQ_DATA, 1'b0, 16'h4000, 16'h0000);
    expectEv(1'b0, n + 3, 1'b1, REQ_DATA, 1'b0, 16'h0000, 16'hBEEF);
    waitGnt(REQ_DATA);
    dropReq(REQ_DATA);
    waitIdle();

    // Three simultaneous reads: debug, then data, then fetch.
    n = cyc;
    applyStimulus(REQ_FETCH, 1'b0, 16'h3000, 16'h0000);
    applyStimulus(REQ_DATA, 1'b0, 16'h4000, 16'h0000);
    applyStimulus(REQ_DBG, 1'b0, 16'h5000, 16'h0000);
    expectEv(1'b0, n + 1,  1'b0, REQ_DBG,   1'b0, 16'h5000, 16'h0000);
    expectEv(1'b0, n + 3,  1'b1, REQ_DBG,   1'b0, 16'h0000, 16'hF5A5);
    expectEv(1'b0, n + 5,  1'b0, REQ_DATA,  1'b0, 16'h4000, 16'h0000);
    expectEv(1'b0, n + 7,  1'b1, REQ_DATA,  1'b0, 16'h0000, 16'hBEEF);
    expectEv(1'b0, n + 9,  1'b0, REQ_FETCH, 1'b0, 16'h3000, 16'h0000);
    expectEv(1'b0, n + 11, 1'b1, REQ_FETCH, 1'b0, 16'h0000, 16'h1234);
    waitGnt(REQ_DBG);
    dropReq(REQ_DBG);
    waitGnt(REQ_DATA);
    dropReq(REQ_DATA);
    waitGnt(REQ_FETCH);
    dropReq(REQ_FETCH);
    waitIdle();

    // Starvation: data writes back to back against a held fetch read.
    n = cyc;
    applyStimulus(REQ_FETCH, 1'b0, 16'h3000, 16'h0000);
    applyStimulus(REQ_DATA, 1'b1, 16'h4100, 16'h0001);
    for (int k = 0; k < 3; k++) expectEv(1'b0, n + 1 + 2 * k, 1'b0, REQ_DATA, 1'b1, 16'h4100, 16'h0001);
    expectEv(1'b0, n + 7, 1'b0, REQ_FETCH, 1'b0, 16'h3000, 16'h0000);
    expectEv(1'b0, n + 9, 1'b1, REQ_FETCH, 1'b0, 16'h0000, 16'h1234);
    for (int k = 0; k < 3; k++) expectEv(1'b0, n + 11 + 2 * k, 1'b0, REQ_DATA, 1'b1, 16'h4100, 16'h0001);
    expectEv(1'b0, n + 17, 1'b0, REQ_FETCH, 1'b0, 16'h3000, 16'h0000);
    expectEv(1'b0, n + 19, 1'b1, REQ_FETCH, 1'b0, 16'h0000, 16'h1234);
    for (int k = 0; k < 6; k++) waitGnt(REQ_DATA);
    dropReq(REQ_DATA);
    waitGnt(REQ_FETCH);
    dropReq(REQ_FETCH);
    waitIdle();

    // Four-cycle read latency on the second instance.
    n = cyc;
    f4_req = 1'b1;
    f4_addr = 16'h3000;
    checkOutput("busy4_sample", 64'(busy4), 64'd0);
    expectEv(1'b1, n + 1, 1'b0, REQ_FETCH, 1'b0, 16'h3000, 16'h0000);
    expectEv(1'b1, n + 6, 1'b1, REQ_FETCH, 1'b0, 16'h0000, 16'h1234);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) f4_req = 1'b0;
      checkOutput($sformatf("busy4_c%0d", k), 64'(busy4), (k <= 6) ? 64'd1 : 64'd0);
    end

    repeat (4) @(negedge clk);
    checkOutput("q1_drained", 64'(q1.size()), 64'd0);
    checkOutput("q4_drained", 64'(q4.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
